// File: rtl/match_timer_ctrl_if.sv
// rtl/match_timer_ctrl_if.sv - control inputs and timing/display outputs of the match timer
interface match_timer_ctrl_if #(
  parameter int SEC_W = 10
);
  logic             start;
  logic             restart;
  logic             count_up;
  logic             frame_tick;
  logic             sec_tick;
  logic [SEC_W-1:0] secs;
  logic             expired;
  logic             running;
  logic [1:0]       state;
  logic [11:0]      bcd;
  logic             bcd_valid;

  modport master (
    output start, restart, count_up,
    input  frame_tick, sec_tick, secs, expired, running, state, bcd, bcd_valid
  );

  modport slave (
    input  start, restart, count_up,
    output frame_tick, sec_tick, secs, expired, running, state, bcd, bcd_valid
  );
endinterface

// File: rtl/match_timer_ctrl.sv
// rtl/match_timer_ctrl.sv - frame/second strobes, match clock FSM and sequential BCD converter
module match_timer_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FRAME_HZ   = 180,
  parameter int MATCH_SECS = 180,
  parameter int SEC_W      = 10
) (
  input logic clk,
  input logic rst_n,
  match_timer_ctrl_if.slave bus
);

  localparam int FRAME_DIV = (CLK_HZ + FRAME_HZ / 2) / FRAME_HZ;
  localparam int SEC_DIV   = CLK_HZ;
  localparam int FW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SW        = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int CW        = (SEC_W > 1) ? $clog2(SEC_W) : 1;
  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [SW-1:0]    SEC_LAST   = SW'(SEC_DIV - 1);
  localparam logic [SEC_W-1:0] MAX_SECS   = SEC_W'(MATCH_SECS);
  localparam logic [CW-1:0]    CONV_LAST  = CW'(SEC_W - 1);
  localparam bit               ZERO_MATCH = (MATCH_SECS == 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e           state_q;
  logic             mode_q;
  logic [FW-1:0]    frame_cnt_q;
  logic [SW-1:0]    sec_cnt_q;
  logic [SEC_W-1:0] secs_q;
  logic             frame_tick_q, sec_tick_q;
  logic             exp_pend_q, expired_q, running_q;

  logic             frame_last, sec_last, final_hit;
  logic [SEC_W-1:0] secs_d, idle_secs;

  always_comb begin
    frame_last = (frame_cnt_q == FRAME_LAST);
    sec_last   = (sec_cnt_q == SEC_LAST);
    idle_secs  = bus.count_up ? '0 : MAX_SECS;
    if (mode_q) begin
      secs_d    = (secs_q >= MAX_SECS) ? MAX_SECS : secs_q + SEC_W'(1);
      final_hit = (secs_d == MAX_SECS);
    end else begin
      secs_d    = (secs_q == '0) ? '0 : secs_q - SEC_W'(1);
      final_hit = (secs_d == '0);
    end
  end

  // Dividers advance in RUN, and in PAUSE on the resume cycle, so a pause costs no phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      frame_cnt_q  <= '0;
      sec_cnt_q    <= '0;
      secs_q       <= MAX_SECS;
      frame_tick_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      exp_pend_q   <= 1'b0;
      expired_q    <= 1'b0;
      running_q    <= 1'b0;
    end else if (bus.restart) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      sec_cnt_q    <= '0;
      secs_q       <= idle_secs;
      frame_tick_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      exp_pend_q   <= 1'b0;
      expired_q    <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      expired_q    <= exp_pend_q;
      exp_pend_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          frame_cnt_q <= '0;
          sec_cnt_q   <= '0;
          secs_q      <= idle_secs;
          if (bus.start) begin
            mode_q <= bus.count_up;
            if (!bus.count_up && ZERO_MATCH) begin
              state_q    <= EXPIRED;
              exp_pend_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
        end
        RUN, PAUSE: begin
          if (bus.start) begin
            state_q      <= RUN;
            running_q    <= 1'b1;
            frame_cnt_q  <= frame_last ? '0 : frame_cnt_q + FW'(1);
            sec_cnt_q    <= sec_last ? '0 : sec_cnt_q + SW'(1);
            frame_tick_q <= frame_last;
            sec_tick_q   <= sec_last;
            if (sec_last) begin
              secs_q <= secs_d;
              if (final_hit) begin
                state_q    <= EXPIRED;
                running_q  <= 1'b0;
                exp_pend_q <= 1'b1;
              end
            end
          end else begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  logic             conv_busy_q, conv_pend_q;
  logic [SEC_W-1:0] conv_last_q, conv_bin_q;
  logic [11:0]      conv_bcd_q, bcd_q;
  logic [CW-1:0]    conv_cnt_q;
  logic             bcd_valid_q;
  logic [11:0]      adj, step_bcd;
  logic [3:0]       dig;

  always_comb begin
    adj = conv_bcd_q;
    dig = '0;
    for (int i = 0; i < 3; i++) begin
      dig = conv_bcd_q[4*i +: 4];
      adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    step_bcd = {adj[10:0], conv_bin_q[SEC_W-1]};
  end

  // Any change of secs (including mid-conversion) restarts from the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_busy_q <= 1'b0;
      conv_pend_q <= 1'b1;
      conv_last_q <= '0;
      conv_bin_q  <= '0;
      conv_bcd_q  <= '0;
      conv_cnt_q  <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else if (conv_pend_q || (secs_q != conv_last_q)) begin
      conv_pend_q <= 1'b0;
      conv_busy_q <= 1'b1;
      conv_last_q <= secs_q;
      conv_bin_q  <= secs_q;
      conv_bcd_q  <= '0;
      conv_cnt_q  <= '0;
      bcd_valid_q <= 1'b0;
    end else if (conv_busy_q) begin
      conv_bcd_q <= step_bcd;
      conv_bin_q <= conv_bin_q << 1;
      conv_cnt_q <= conv_cnt_q + CW'(1);
      if (conv_cnt_q == CONV_LAST) begin
        conv_busy_q <= 1'b0;
        bcd_q       <= step_bcd;
        bcd_valid_q <= 1'b1;
      end
    end
  end

  assign bus.frame_tick = frame_tick_q;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.secs       = secs_q;
  assign bus.expired    = expired_q;
  assign bus.running    = running_q;
  assign bus.state      = state_q;
  assign bus.bcd        = bcd_q;
  assign bus.bcd_valid  = bcd_valid_q;

endmodule

// File: tb/tb_match_timer_ctrl.sv
// tb/tb_match_timer_ctrl.sv - randomized and directed bench for match_timer_ctrl with a reference model
module tb_match_timer_ctrl;
  localparam int M    = 3;
  localparam int SW   = 4;
  localparam int FDIV = 10;
  localparam int SDIV = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_timer_ctrl_if #(.SEC_W(4))  tif ();
  match_timer_ctrl_if #(.SEC_W(10)) tif999 ();
  match_timer_ctrl_if #(.SEC_W(4))  tif0 ();

  match_timer_ctrl #(.CLK_HZ(1000), .FRAME_HZ(100), .MATCH_SECS(3), .SEC_W(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(tif));
  match_timer_ctrl #(.CLK_HZ(1000), .FRAME_HZ(100), .MATCH_SECS(999), .SEC_W(10))
    dut999 (.clk(clk), .rst_n(rst_n), .bus(tif999));
  match_timer_ctrl #(.CLK_HZ(1000), .FRAME_HZ(100), .MATCH_SECS(0), .SEC_W(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(tif0));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: elapsed active cycles drive everything by plain arithmetic.
  int m_state, m_secs, m_mode, m_act;
  bit m_ft, m_st, m_exp, m_pend;
  bit m_have, m_first, m_bv;
  int m_ls, m_prev, m_conv;
  logic [11:0] m_bcd;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update(input bit s, input bit r, input bit cu);
    int el;
    if (!rst_n) begin
      m_have = 0; m_first = 1;
    end else begin
      if (m_first || m_secs != m_prev) begin
        m_have = 1; m_ls = cyc; m_conv = m_secs;
      end
      m_first = 0;
    end
    m_prev = m_secs;
    if (m_have && (cyc + 1 - m_ls >= SW + 1) && !m_bv) m_bcd = to_bcd(m_conv);
    m_bv = m_have && (cyc + 1 - m_ls >= SW + 1);
    if (!rst_n) begin
      m_bcd = '0;
      m_state = 0; m_secs = M; m_mode = 0; m_act = 0;
      m_ft = 0; m_st = 0; m_exp = 0; m_pend = 0;
    end else if (r) begin
      m_state = 0; m_secs = cu ? 0 : M; m_act = 0;
      m_ft = 0; m_st = 0; m_exp = 0; m_pend = 0;
    end else begin
      m_exp = m_pend; m_pend = 0; m_ft = 0; m_st = 0;
      if (m_state == 0) begin
        m_act = 0;
        m_secs = cu ? 0 : M;
        if (s) begin m_mode = cu; m_state = 1; end
      end else if (m_state != 3) begin
        if (s) begin
          m_state = 1;
          m_act++;
          m_ft = (m_act % FDIV == 0);
          m_st = (m_act % SDIV == 0);
          if (m_st) begin
            el = m_act / SDIV;
            m_secs = m_mode ? ((el < M) ? el : M) : ((el < M) ? M - el : 0);
            if (el >= M) begin m_state = 3; m_pend = 1; end
          end
        end else m_state = 2;
      end
    end
  endtask

  task automatic step(input bit s, input bit r, input bit cu);
    tif.start = s; tif.restart = r; tif.count_up = cu;
    @(posedge clk);
    model_update(s, r, cu);
    @(negedge clk);
    cyc++;
    chk("state", 32'(tif.state), 32'(m_state));
    chk("secs", 32'(tif.secs), 32'(m_secs));
    chk("frame_tick", 32'(tif.frame_tick), 32'(m_ft));
    chk("sec_tick", 32'(tif.sec_tick), 32'(m_st));
    chk("expired", 32'(tif.expired), 32'(m_exp));
    chk("running", 32'(tif.running), 32'(m_state == 1));
    chk("bcd_valid", 32'(tif.bcd_valid), 32'(m_bv));
    chk("bcd", 32'(tif.bcd), 32'(m_bcd));
  endtask

  initial begin
    int entry, npulse, nft, first_tk, rel;
    int tk[$];
    bit s, cu;
    tif.start = 0; tif.restart = 0; tif.count_up = 0;
    tif999.start = 0; tif999.restart = 0; tif999.count_up = 0;
    tif0.start = 0; tif0.restart = 0; tif0.count_up = 0;
    m_secs = M; m_prev = M; m_bv = 0; m_bcd = '0; m_first = 1; m_have = 0;

    rst_n = 0;
    repeat (3) step(0, 0, 0);
    chk("reset_state", 32'(tif.state), 0);
    chk("reset_secs", 32'(tif.secs), 3);
    rst_n = 1;
    repeat (12) step(0, 0, 0);
    chk("m999_bcd", 32'(tif999.bcd), 32'h999);
    chk("m999_bcd_valid", 32'(tif999.bcd_valid), 1);
    chk("m0_idle", 32'(tif0.state), 0);

    // Countdown to expiry, then restart on the would-be tick at 4000.
    step(1, 0, 0);
    entry = cyc; npulse = 0;
    while (cyc - entry < 3999) begin
      step(1, 0, 0);
      rel = cyc - entry;
      if (tif.sec_tick) tk.push_back(rel);
      if (tif.expired) npulse++;
      if (rel == 1005) begin
        chk("bcd_at_2", 32'(tif.bcd), 32'h002);
        chk("bcd_valid_at_2", 32'(tif.bcd_valid), 1);
      end
    end
    chk("down_ticks", 32'(tk.size()), 3);
    if (tk.size() == 3) begin
      chk("down_tick1", 32'(tk[0]), 1000);
      chk("down_tick3", 32'(tk[2]), 3000);
    end
    chk("down_pulses", 32'(npulse), 1);
    chk("down_state", 32'(tif.state), 3);
    step(1, 1, 0);
    chk("rst_exp_state", 32'(tif.state), 0);
    chk("rst_exp_secs", 32'(tif.secs), 3);
    chk("rst_exp_tick", 32'(tif.sec_tick), 0);
    step(0, 0, 0);

    // Count-up with count_up wiggling mid-run.
    step(1, 0, 1);
    entry = cyc;
    while (cyc - entry < 3010) step(1, 0, 1'($urandom_range(0, 1)));
    chk("up_secs", 32'(tif.secs), 3);
    chk("up_state", 32'(tif.state), 3);
    step(0, 1, 0);

    // Pause at RUN cycle 505 for 200 cycles.
    step(1, 0, 0);
    entry = cyc; nft = 0; first_tk = -1;
    while (cyc - entry < 505) step(1, 0, 0);
    repeat (200) begin
      step(0, 0, 0);
      if (tif.frame_tick) nft++;
    end
    chk("pause_frames", 32'(nft), 0);
    while (cyc - entry < 1300 && first_tk < 0) begin
      step(1, 0, 0);
      if (tif.sec_tick) first_tk = cyc - entry;
    end
    chk("pause_tick_at", 32'(first_tk), 1200);
    while (cyc - entry < 2199) step(1, 0, 0);
    step(1, 1, 0);
    chk("rst_run_state", 32'(tif.state), 0);
    chk("rst_run_secs", 32'(tif.secs), 3);
    chk("rst_run_tick", 32'(tif.sec_tick), 0);
    step(0, 0, 0);

    // Random start/restart/mode activity.
    s = 0; cu = 0;
    for (int i = 0; i < 5000; i++) begin
      if (s ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 19) == 0)) s = !s;
      if ($urandom_range(0, 99) == 0) cu = 1'($urandom_range(0, 1));
      step(s, ($urandom_range(0, 999) == 0), cu);
    end
    step(0, 1, 0);

    // Reset mid-RUN.
    repeat (300) step(1, 0, 0);
    rst_n = 0;
    step(1, 0, 0);
    chk("rst_mid_state", 32'(tif.state), 0);
    chk("rst_mid_running", 32'(tif.running), 0);
    chk("rst_mid_bcd", 32'(tif.bcd), 0);
    rst_n = 1;
    step(0, 0, 0);

    // MATCH_SECS=0 countdown start goes straight to EXPIRED.
    tif0.start = 1;
    step(0, 0, 0);
    chk("m0_state", 32'(tif0.state), 3);
    chk("m0_exp_first", 32'(tif0.expired), 0);
    step(0, 0, 0);
    chk("m0_exp_pulse", 32'(tif0.expired), 1);
    step(0, 0, 0);
    chk("m0_exp_after", 32'(tif0.expired), 0);
    chk("m0_state_hold", 32'(tif0.state), 3);
    tif0.start = 0;
    repeat (6) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
